sd_read_ctrl: RTL and testbench



---
 rtl/sd_read_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sd_read_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_read_ctrl.sv
// SD-card SPI-mode sequencer: runs the init handshake, then serves
// 512-byte CMD17 sector reads through the SPI session engine.
module sd_read_ctrl #(
    parameter logic [31:0] INIT_CLKDIV    = 32'd124,
    parameter logic [31:0] FAST_CLKDIV    = 32'd2,
    parameter logic [15:0] CMD0_RETRIES   = 16'd8,
    parameter logic [15:0] ACMD41_RETRIES = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        sess_start_o,
    input  logic        sess_done_i,
    output logic [31:0] sess_clkdiv_o,
    output logic [47:0] sess_cmd_o,
    output logic [47:0] sess_acmd_o,
    output logic [79:0] sess_cyc_o,
    input  logic [7:0]  sess_cmdrsp_i,
    input  logic [7:0]  sess_acmdrsp_i,
    input  logic [7:0]  sess_rwrsp_i,
    input  logic [47:0] sess_cmdres_i,
    input  logic        sess_rvalid_i,
    input  logic [15:0] sess_rindex_i,
    input  logic [7:0]  sess_rdata_i,
    output logic        init_done_o,
    output logic        sdhc_o,
    output logic        err_o,
    output logic [2:0]  err_code_o,
    input  logic        rd_req_i,
    input  logic [31:0] rd_sector_i,
    output logic        rd_ready_o,
    output logic        rd_valid_o,
    output logic [7:0]  rd_data_o,
    output logic [8:0]  rd_addr_o,
    output logic        rd_last_o,
    output logic        rd_done_o,
    output logic        rd_ok_o
);

    typedef enum logic [3:0] {
        S_INIT0, S_CMD0, S_CMD8, S_APP41, S_CMD58,
        S_READY, S_READ, S_GAP, S_ERROR
    } state_t;

    state_t      state_q, state_d, last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  cmdrsp_q, cmdrsp_d, acmdrsp_q, acmdrsp_d;
    logic [12:0] res_q, res_d;
    logic        v2_q, v2_d, sdhc_q, sdhc_d;
    logic [2:0]  code_q, code_d;
    logic [31:0] sector_q, sector_d;
    logic        fast_q, init_q, err_q;
    logic        start_q, start_d;
    logic [47:0] cmd_q, cmd_d, acmd_q, acmd_d;
    logic [79:0] cyc_q, cyc_d;
    logic        rd_valid_q, rd_last_q, rd_done_q, rd_ok_q;
    logic [7:0]  rd_data_q;
    logic [8:0]  rd_addr_q;
    logic        unused_bits;

    // only the CMD8 echo and the OCR CCS bit are ever inspected
    assign unused_bits = ^{sess_cmdres_i[47:31], sess_cmdres_i[29:12]};

    function automatic logic [79:0] mk_cyc(input logic [7:0] pre,
                                           input logic [7:0] cmdr,
                                           input logic [7:0] acmd,
                                           input logic [7:0] mid);
        return {8'd0, pre, 8'd1, 8'd6, cmdr, acmd, 8'd0, mid, 8'd1, 8'd1};
    endfunction

    // next-state: capture responses on sess_done, decide in GAP
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        cmdrsp_d  = cmdrsp_q;
        acmdrsp_d = acmdrsp_q;
        res_d     = res_q;
        v2_d      = v2_q;
        sdhc_d    = sdhc_q;
        code_d    = code_q;
        sector_d  = sector_q;
        unique case (state_q)
            S_INIT0: state_d = S_CMD0;
            S_CMD0, S_CMD8, S_APP41, S_CMD58, S_READ: begin
                if (sess_done_i) begin
                    state_d   = S_GAP;
                    last_d    = state_q;
                    cmdrsp_d  = sess_cmdrsp_i;
                    acmdrsp_d = sess_acmdrsp_i;
                    res_d     = {sess_cmdres_i[30], sess_cmdres_i[11:0]};
                    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                unique case (last_q)
                    S_CMD0: begin
                        if (cmdrsp_q == 8'h01) begin
                            state_d = S_CMD8;
                        end else if (cnt_q >= CMD0_RETRIES) begin
                            state_d = S_ERROR;
                            code_d  = 3'd1;
                        end else begin
                            state_d = S_CMD0;
                        end
                    end
                    S_CMD8: begin
                        if (cmdrsp_q == 8'h01 && res_q[11:0] == 12'h1AA) begin
                            v2_d    = 1'b1;
                            state_d = S_APP41;
                        end else if (cmdrsp_q[2]) begin
                            v2_d    = 1'b0;
                            state_d = S_APP41;
                        end else begin
                            state_d = S_ERROR;
                            code_d  = 3'd2;
                        end
                    end
                    S_APP41: begin
                        if (acmdrsp_q == 8'h00) begin
                            state_d = v2_q ? S_CMD58 : S_READY;
                        end else if (cnt_q >= ACMD41_RETRIES) begin
                            state_d = S_ERROR;
                            code_d  = 3'd3;
                        end else begin
                            state_d = S_APP41;
                        end
                    end
                    S_CMD58: begin
                        sdhc_d  = res_q[12];
                        state_d = S_READY;
                    end
                    default: state_d = S_READY;
                endcase
                if (state_d != last_q) cnt_d = '0;
            end
            S_READY: begin
                if (rd_req_i) begin
                    state_d  = S_READ;
                    sector_d = rd_sector_i;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_INIT0;
        endcase
    end

    // session fields for the state being entered, registered with start
    always_comb begin
        start_d = 1'b0;
        cmd_d   = cmd_q;
        acmd_d  = acmd_q;
        cyc_d   = cyc_q;
        unique case (state_d)
            S_CMD0: begin
                start_d = 1'b1;
                cmd_d   = 48'h400000000095;
                cyc_d   = mk_cyc(8'd10, 8'd0, 8'd0, 8'd0);
            end
            S_CMD8: begin
                start_d = 1'b1;
                cmd_d   = 48'h48000001AA87;
                cyc_d   = mk_cyc(8'd1, 8'd4, 8'd0, 8'd0);
            end
            S_APP41: begin
                start_d = 1'b1;
                cmd_d   = 48'h7700000000FF;
                acmd_d  = v2_d ? 48'h6940000000FF : 48'h6900000000FF;
                cyc_d   = mk_cyc(8'd1, 8'd0, 8'd6, 8'd0);
            end
            S_CMD58: begin
                start_d = 1'b1;
                cmd_d   = 48'h7A00000000FF;
                cyc_d   = mk_cyc(8'd1, 8'd4, 8'd0, 8'd0);
            end
            S_READ: begin
                start_d = 1'b1;
                cmd_d   = {8'h51,
                           sdhc_q ? sector_d : {sector_d[22:0], 9'd0},
                           8'hFF};
                cyc_d   = mk_cyc(8'd1, 8'd0, 8'd0, 8'd255);
            end
            default: ;
        endcase
    end

    // control state and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT0;
            last_q    <= S_INIT0;
            cnt_q     <= '0;
            cmdrsp_q  <= '0;
            acmdrsp_q <= '0;
            res_q     <= '0;
            v2_q      <= 1'b0;
            sdhc_q    <= 1'b0;
            code_q    <= '0;
            sector_q  <= '0;
            fast_q    <= 1'b0;
            init_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            cmdrsp_q  <= cmdrsp_d;
            acmdrsp_q <= acmdrsp_d;
            res_q     <= res_d;
            v2_q      <= v2_d;
            sdhc_q    <= sdhc_d;
            code_q    <= code_d;
            sector_q  <= sector_d;
            fast_q    <= fast_q | (state_d == S_READY);
            init_q    <= init_q | (state_d == S_READY);
            err_q     <= err_q | (state_d == S_ERROR);
        end
    end

    // session request and its constant fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            cmd_q   <= '1;
            acmd_q  <= '1;
            cyc_q   <= '0;
        end else begin
            start_q <= start_d;
            cmd_q   <= cmd_d;
            acmd_q  <= acmd_d;
            cyc_q   <= cyc_d;
        end
    end

    // data byte stream (CRC bytes dropped) and end-of-sector status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            rd_valid_q <= (state_q == S_READ) && sess_rvalid_i &&
                          (sess_rindex_i >= 16'd3);
            if (sess_rvalid_i) begin
                rd_data_q <= sess_rdata_i;
                rd_addr_q <= 9'd2 - sess_rindex_i[8:0];
                rd_last_q <= (sess_rindex_i == 16'd3);
            end
            rd_done_q <= (state_q == S_READ) && sess_done_i;
            if ((state_q == S_READ) && sess_done_i) begin
                rd_ok_q <= (sess_cmdrsp_i == 8'h00) &&
                           (sess_rwrsp_i == 8'hFE);
            end
        end
    end

    assign sess_start_o  = start_q;
    assign sess_clkdiv_o = fast_q ? FAST_CLKDIV : INIT_CLKDIV;
    assign sess_cmd_o    = cmd_q;
    assign sess_acmd_o   = acmd_q;
    assign sess_cyc_o    = cyc_q;
    assign init_done_o   = init_q & ~err_q;
    assign sdhc_o        = sdhc_q;
    assign err_o         = err_q;
    assign err_code_o    = code_q;
    assign rd_ready_o    = (state_q == S_READY);
    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_data_q;
    assign rd_addr_o     = rd_addr_q;
    assign rd_last_o     = rd_last_q & rd_valid_q;
    assign rd_done_o     = rd_done_q;
    assign rd_ok_o       = rd_ok_q;

endmodule

// File: tb/tb_sd_read_ctrl.sv
// Bench for sd_read_ctrl: behavioural SD card behind a session-engine
// model, directed steps with randomized card behaviour and data.
module tb_sd_read_ctrl;

    logic        clk, rst_n;
    logic        sess_start, sess_done;
    logic [31:0] sess_clkdiv;
    logic [47:0] sess_cmd, sess_acmd, sess_cmdres;
    logic [79:0] sess_cyc;
    logic [7:0]  sess_cmdrsp, sess_acmdrsp, sess_rwrsp, sess_rdata;
    logic        sess_rvalid;
    logic [15:0] sess_rindex;
    logic        init_done, sdhc, err;
    logic [2:0]  err_code;
    logic        rd_req, rd_ready, rd_valid, rd_last, rd_done, rd_ok;
    logic [31:0] rd_sector;
    logic [7:0]  rd_data;
    logic [8:0]  rd_addr;

    sd_read_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .sess_start_o(sess_start), .sess_done_i(sess_done),
        .sess_clkdiv_o(sess_clkdiv), .sess_cmd_o(sess_cmd),
        .sess_acmd_o(sess_acmd), .sess_cyc_o(sess_cyc),
        .sess_cmdrsp_i(sess_cmdrsp), .sess_acmdrsp_i(sess_acmdrsp),
        .sess_rwrsp_i(sess_rwrsp), .sess_cmdres_i(sess_cmdres),
        .sess_rvalid_i(sess_rvalid), .sess_rindex_i(sess_rindex),
        .sess_rdata_i(sess_rdata),
        .init_done_o(init_done), .sdhc_o(sdhc), .err_o(err),
        .err_code_o(err_code),
        .rd_req_i(rd_req), .rd_sector_i(rd_sector), .rd_ready_o(rd_ready),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_addr_o(rd_addr),
        .rd_last_o(rd_last), .rd_done_o(rd_done), .rd_ok_o(rd_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks, errors;

    // card model configuration: 0 v2, 1 v1, 2 dead, 3 bad CMD8 echo
    int          mode;
    bit          c_sdhc;
    int          busy_left;
    logic [7:0]  token;
    logic [7:0]  rdmem [0:513];

    logic [7:0]  sess_log[$];
    logic [31:0] rd_args[$];
    logic [79:0] first_cyc, read_cyc;
    logic [47:0] last_acmd;

    logic [8:0]  mon_addr[$];
    logic [7:0]  mon_data[$];
    logic        mon_last[$];
    int          done_cnt;
    logic        done_ok;

    task automatic check(input string tag, input logic [79:0] obs,
                         input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int n_cmd(input logic [7:0] b);
        int n = 0;
        foreach (sess_log[i]) if (sess_log[i] == b) n++;
        return n;
    endfunction

    task automatic eng_clear();
        sess_done   = 1'b0;
        sess_rvalid = 1'b0;
        sess_rindex = '0;
        sess_rdata  = '0;
    endtask

    task automatic eng_tick(output bit ab);
        @(posedge clk);
        #1;
        ab = !rst_n;
    endtask

    // one session: the card answers according to the command index
    task automatic run_session();
        logic [7:0] idx;
        bit ab;
        idx = sess_cmd[47:40];
        if (sess_log.size() == 0) first_cyc = sess_cyc;
        sess_log.push_back(idx);
        if (idx == 8'h51) begin
            rd_args.push_back(sess_cmd[39:8]);
            read_cyc = sess_cyc;
        end
        if (idx == 8'h77) last_acmd = sess_acmd;
        repeat ($urandom_range(2, 5)) begin
            eng_tick(ab);
            if (ab) begin eng_clear(); return; end
        end
        sess_cmdrsp  = 8'hFF;
        sess_acmdrsp = 8'hFF;
        sess_rwrsp   = 8'hFF;
        sess_cmdres  = {16'($urandom), 32'($urandom)};
        case (idx)
            8'h40: sess_cmdrsp = (mode == 2) ? 8'h00 : 8'h01;
            8'h48: begin
                if (mode == 1) sess_cmdrsp = 8'h05;
                else begin
                    sess_cmdrsp = 8'h01;
                    sess_cmdres[11:0] = (mode == 3) ? 12'h1A5 : 12'h1AA;
                end
            end
            8'h77: begin
                sess_cmdrsp  = 8'h01;
                sess_acmdrsp = (busy_left > 0) ? 8'h01 : 8'h00;
                if (busy_left > 0) busy_left--;
            end
            8'h7A: begin
                sess_cmdrsp     = 8'h00;
                sess_cmdres[30] = c_sdhc;
            end
            8'h51: begin
                sess_cmdrsp = 8'h00;
                sess_rwrsp  = token;
                if (token == 8'hFE) begin
                    for (int r = 514; r >= 1; r--) begin
                        sess_rvalid = 1'b1;
                        sess_rindex = 16'(r);
                        sess_rdata  = rdmem[514 - r];
                        eng_tick(ab);
                        sess_rvalid = 1'b0;
                        if (ab) begin eng_clear(); return; end
                        repeat (2) begin
                            eng_tick(ab);
                            if (ab) begin eng_clear(); return; end
                        end
                    end
                end
            end
            default: ;
        endcase
        sess_done = 1'b1;
        eng_tick(ab);
        eng_clear();
    endtask

    initial begin
        eng_clear();
        sess_cmdrsp  = '0;
        sess_acmdrsp = '0;
        sess_rwrsp   = '0;
        sess_cmdres  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sess_start) run_session();
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            mon_addr.push_back(rd_addr);
            mon_data.push_back(rd_data);
            mon_last.push_back(rd_last);
        end
        if (rst_n && rd_done) begin
            done_cnt++;
            done_ok = rd_ok;
        end
    end

    task automatic clear_logs();
        sess_log.delete();
        rd_args.delete();
        mon_addr.delete();
        mon_data.delete();
        mon_last.delete();
        done_cnt = 0;
    endtask

    task automatic reset_card(input int m, input bit s, input int busy);
        rst_n = 1'b0;
        mode = m;
        c_sdhc = s;
        busy_left = busy;
        repeat (3) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rd_ready === 1'b1) begin ok = 1; break; end
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_err(input string tag);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin ok = 1; break; end
        end
        check(tag, ok, 1);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 514; i++) rdmem[i] = 8'($urandom);
    endtask

    task automatic do_read(input logic [31:0] sec, input bit exp_ok);
        bit got = 0;
        int n0;
        logic [31:0] exp_arg;
        exp_arg = c_sdhc ? sec : (sec << 9);
        mon_addr.delete();
        mon_data.delete();
        mon_last.delete();
        done_cnt = 0;
        n0 = n_cmd(8'h51);
        @(negedge clk);
        rd_req = 1'b1;
        rd_sector = sec;
        @(negedge clk);
        rd_req = 1'b0;
        check("rd_ready_drop", rd_ready, 0);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin got = 1; break; end
            if (i == 100) begin rd_req = 1'b1; rd_sector = ~sec; end
            if (i == 101) rd_req = 1'b0;
        end
        rd_req = 1'b0;
        check("rd_done_seen", got, 1);
        check("rd_done_once", done_cnt, 1);
        check("rd_arg", (rd_args.size() > 0) ? rd_args[$] : 32'hx, exp_arg);
        check("rd_cyc", read_cyc,
              {8'd0, 8'd1, 8'd1, 8'd6, 8'd0, 8'd0, 8'd0, 8'd255, 8'd1, 8'd1});
        check("rd_ok", done_ok, exp_ok);
        check("rd_count", mon_addr.size(), exp_ok ? 512 : 0);
        foreach (mon_addr[i]) begin
            check("rd_addr", mon_addr[i], i);
            check("rd_data", mon_data[i], rdmem[i]);
            check("rd_last", mon_last[i], (i == 511));
        end
        @(negedge clk);
        check("rd_ready_back", rd_ready, 1);
        check("rd_no_err", err, 0);
        repeat (20) @(negedge clk);
        check("rd_not_queued", n_cmd(8'h51) - n0, 1);
    endtask

    initial begin
        logic [31:0] sec;
        int busy;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rd_req = 1'b0;
        rd_sector = '0;
        done_cnt = 0;
        done_ok = 1'b0;
        token = 8'hFE;
        first_cyc = '0;
        read_cyc = '0;
        last_acmd = '0;
        mode = 0;
        repeat (3) @(negedge clk);
        check("rst_start", sess_start, 0);
        check("rst_clkdiv", sess_clkdiv, 124);
        check("rst_cmd", sess_cmd, 48'hFFFF_FFFF_FFFF);
        check("rst_acmd", sess_acmd, 48'hFFFF_FFFF_FFFF);
        check("rst_cyc", sess_cyc, 0);
        check("rst_status", {init_done, sdhc, err, err_code}, 0);
        check("rst_rd", {rd_ready, rd_valid, rd_done, rd_ok}, 0);

        // v2 SDHC card, busy for three ACMD41 rounds
        reset_card(0, 1, 3);
        wait_ready("v2_ready");
        check("v2_n_cmd0", n_cmd(8'h40), 1);
        check("v2_n_cmd8", n_cmd(8'h48), 1);
        check("v2_n_app41", n_cmd(8'h77), 4);
        check("v2_n_cmd58", n_cmd(8'h7A), 1);
        check("v2_cmd0_cyc", first_cyc,
              {8'd0, 8'd10, 8'd1, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1});
        check("v2_acmd", last_acmd, 48'h6940000000FF);
        check("v2_flags", {init_done, sdhc, err}, 3'b110);
        check("v2_clkdiv", sess_clkdiv, 2);

        fill_mem();
        token = 8'hFE;
        do_read(32'h12345678, 1);
        for (int k = 0; k < 2; k++) begin
            fill_mem();
            sec = $urandom;
            token = ($urandom_range(0, 1) == 1) ? 8'hFE
                                                : 8'($urandom_range(0, 253));
            do_read(sec, token == 8'hFE);
        end
        token = 8'h00;
        do_read(32'd77, 0);

        // v1 card: no CMD58, byte addressing
        busy = $urandom_range(0, 4);
        reset_card(1, 1, busy);
        wait_ready("v1_ready");
        check("v1_n_app41", n_cmd(8'h77), busy + 1);
        check("v1_n_cmd58", n_cmd(8'h7A), 0);
        check("v1_acmd", last_acmd, 48'h6900000000FF);
        check("v1_sdhc", sdhc, 0);
        c_sdhc = 1'b0;
        fill_mem();
        token = 8'hFE;
        do_read(32'd3, 1);
        check("v1_arg_600", rd_args[$], 32'h0000_0600);

        // dead card: CMD0 never answers 0x01
        reset_card(2, 0, 0);
        wait_err("dead_err");
        check("dead_code", err_code, 1);
        check("dead_n_cmd0", n_cmd(8'h40), 8);
        repeat (300) @(negedge clk);
        check("dead_no_more", sess_log.size(), 8);
        check("dead_idle", {sess_start, init_done, rd_ready}, 0);

        // CMD8 echo mismatch
        reset_card(3, 0, 0);
        wait_err("cmd8_err");
        check("cmd8_code", err_code, 2);
        check("cmd8_n", {8'(n_cmd(8'h40)), 8'(n_cmd(8'h48))}, 16'h0101);

        // async reset in the middle of a sector
        reset_card(0, 0, 0);
        wait_ready("mid_ready");
        fill_mem();
        token = 8'hFE;
        @(negedge clk);
        rd_req = 1'b1;
        rd_sector = 32'd9;
        @(negedge clk);
        rd_req = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (rd_valid === 1'b1 && rd_addr == 9'd299) begin
                    hit = 1;
                    break;
                end
            end
            check("mid_byte300", hit, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_async", {sess_start, rd_valid}, 0);
        repeat (3) @(negedge clk);
        clear_logs();
        busy_left = 1;
        rst_n = 1'b1;
        wait_ready("mid_reinit");
        check("mid_first", (sess_log.size() > 0) ? sess_log[0] : 8'hx, 8'h40);
        check("mid_n_cmd0", n_cmd(8'h40), 1);
        check("mid_n_app41", n_cmd(8'h77), 2);
        check("mid_init", init_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
